// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared state type, digest constants and helpers for the SHA-1 loader
package sha1_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      CRST  = 3'd2,
      START = 3'd3,
      WAIT  = 3'd4,
      OUT   = 3'd5
   } state_e;

   localparam logic [31:0] H0 = 32'h67452301;
   localparam logic [31:0] H1 = 32'hefcdab89;
   localparam logic [31:0] H2 = 32'h98badcfe;
   localparam logic [31:0] H3 = 32'h10325476;
   localparam logic [31:0] H4 = 32'hc3d2e1f0;

   localparam int DIGEST_WORDS = 5;

   // Word 0 is the most significant 32 bits of the digest.
   function automatic logic [31:0] digest_word(input logic [159:0] d, input logic [2:0] idx);
      logic [31:0] w;
      case (idx)
         3'd0:    w = d[159:128];
         3'd1:    w = d[127:96];
         3'd2:    w = d[95:64];
         3'd3:    w = d[63:32];
         default: w = d[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sha1_byte_packer.sv
// rtl/sha1_byte_packer.sv - packs message bytes into little-lane 32-bit words and issues SRAM writes
module sha1_byte_packer
   import sha1_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] byte_off,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data
);

   logic [31:0]       acc_q,  acc_d;
   logic              we_q,   we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       merged;
   logic [1:0]        lane;

   assign lane   = byte_off[1:0];
   assign merged = acc_q | ({24'd0, in_data} << {lane, 3'b000});

   // A word is flushed when its top lane fills or the message ends early;
   // the write appears the cycle after the byte is accepted.
   always_comb begin
      acc_d  = acc_q;
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (in_valid) begin
         if (lane == 2'd3 || in_last) begin
            we_d   = 1'b1;
            addr_d = base + {byte_off[ADDR_W-1:2], 2'b00};
            data_d = merged;
            acc_d  = 32'd0;
         end else begin
            acc_d = merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= 32'd0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= 32'd0;
      end else begin
         acc_q  <= acc_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign wr_en   = we_q;
   assign wr_addr = addr_q;
   assign wr_data = data_q;

endmodule

// File: rtl/sha1_msg_loader.sv
// rtl/sha1_msg_loader.sv - loads a byte-stream message into SRAM, runs the SHA-1 core, streams out the digest
module sha1_msg_loader
   import sha1_pkg::*;
#(
   parameter int MAX_BYTES = 4096,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              port_B_clk,
   output logic [ADDR_W-1:0] port_B_addr,
   output logic [31:0]       port_B_data_in,
   output logic              port_B_we,
   output logic              core_nreset,
   output logic              start_hash,
   output logic [31:0]       message_addr,
   output logic [31:0]       message_size,
   input  logic              done,
   input  logic [159:0]      hash,
   output logic              h_valid,
   input  logic              h_ready,
   output logic [31:0]       h_data,
   output logic              h_last,
   output logic              busy,
   output logic              overflow
);

   localparam logic [31:0] MAX_CNT  = 32'(MAX_BYTES);
   localparam logic [2:0]  LAST_IDX = 3'(DIGEST_WORDS - 1);

   state_e            state_q,  state_d;
   logic [ADDR_W-1:0] base_q,   base_d;
   logic [31:0]       cnt_q,    cnt_d;
   logic              ovf_q,    ovf_d;
   logic [31:0]       size_q,   size_d;
   logic [159:0]      digest_q, digest_d;
   logic [2:0]        widx_q,   widx_d;

   logic              accept;
   logic              counted;
   logic [31:0]       cnt_eff;
   logic [ADDR_W-1:0] base_eff;

   // The first byte of a job is taken in IDLE, so its count and base come
   // straight from reset values and the input port rather than the registers.
   assign cnt_eff  = (state_q == IDLE) ? 32'd0 : cnt_q;
   assign base_eff = (state_q == IDLE) ? base_addr : base_q;
   assign accept   = s_valid & s_ready;
   assign counted  = accept & (cnt_eff < MAX_CNT);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      size_d   = size_q;
      digest_d = digest_q;
      widx_d   = widx_q;
      case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               if (state_q == IDLE) begin
                  base_d = base_addr;
                  ovf_d  = 1'b0;
               end
               // Bytes past capacity are swallowed so the upstream never stalls.
               if (counted) begin
                  cnt_d = cnt_eff + 32'd1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (s_last) begin
                  size_d  = counted ? (cnt_eff + 32'd1) : MAX_CNT;
                  state_d = CRST;
               end else begin
                  state_d = FILL;
               end
            end
         end
         CRST: begin
            state_d = START;
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (done) begin
               digest_d = hash;
               widx_d   = 3'd0;
               state_d  = OUT;
            end
         end
         OUT: begin
            if (h_ready) begin
               if (widx_q == LAST_IDX) begin
                  widx_d  = 3'd0;
                  state_d = IDLE;
               end else begin
                  widx_d = widx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         cnt_q    <= 32'd0;
         ovf_q    <= 1'b0;
         size_q   <= 32'd0;
         digest_q <= 160'd0;
         widx_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         size_q   <= size_d;
         digest_q <= digest_d;
         widx_q   <= widx_d;
      end
   end

   sha1_byte_packer #(
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk      (clk),
      .reset    (reset),
      .in_valid (counted),
      .in_data  (s_data),
      .in_last  (s_last),
      .base     (base_eff),
      .byte_off (cnt_eff[ADDR_W-1:0]),
      .wr_en    (port_B_we),
      .wr_addr  (port_B_addr),
      .wr_data  (port_B_data_in)
   );

   assign port_B_clk   = clk;
   assign s_ready      = ~reset & ((state_q == IDLE) | (state_q == FILL));
   assign core_nreset  = ~reset & (state_q != CRST);
   assign start_hash   = (state_q == START);
   assign busy         = (state_q != IDLE);
   assign overflow     = ovf_q;
   assign message_addr = {{(32-ADDR_W){1'b0}}, base_q};
   assign message_size = size_q;
   assign h_valid      = (state_q == OUT);
   assign h_last       = h_valid & (widx_q == LAST_IDX);
   assign h_data       = digest_word(digest_q, widx_q);

endmodule

// File: tb/tb_sha1_msg_loader.sv
// tb/tb_sha1_msg_loader.sv - self-checking bench for sha1_msg_loader with a hasher and SRAM-write model
module tb_sha1_msg_loader;
   import sha1_pkg::*;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
   typedef struct {
      bit            sel;
      logic [15:0]   base;
      string         msg;
      logic [159:0]  digest;
      bit            stall;
      int            exp_writes;
      logic [31:0]   exp_size;
      bit            exp_ovf;
      logic [31:0]   exp_w0;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [15:0]  base_addr = '0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic [7:0]   s_data = '0;
   logic         done = 1'b0;
   logic [159:0] hash = '0;
   logic         h_ready = 1'b0;
   logic         sel = 1'b0;

   logic [1:0]        s_ready_o, pclk_o, pwe_o, cnr_o, start_o, hv_o, hl_o, busy_o, ovf_o;
   logic [1:0][15:0]  paddr_o;
   logic [1:0][31:0]  pdata_o, maddr_o, msize_o, hd_o;

   logic        m_s_ready, m_we, m_cnr, m_start, m_hv, m_hl, m_busy, m_ovf;
   logic [15:0] m_paddr;
   logic [31:0] m_pdata, m_maddr, m_msize, m_hd;

   int checks = 0;
   int errors = 0;

   wr_t          wq[$];
   int           starts = 0;
   int           nres_lows = 0;
   int           hash_cnt = 0;
   logic [31:0]  cap_size = '0;
   logic [31:0]  cap_addr = '0;
   logic [159:0] cur_digest = '0;

   always #5 clk = ~clk;

   sha1_msg_loader #(.MAX_BYTES(64), .ADDR_W(16)) dut0 (
      .clk(clk), .reset(reset), .base_addr(base_addr),
      .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_data(s_data), .s_last(s_last),
      .port_B_clk(pclk_o[0]), .port_B_addr(paddr_o[0]), .port_B_data_in(pdata_o[0]), .port_B_we(pwe_o[0]),
      .core_nreset(cnr_o[0]), .start_hash(start_o[0]), .message_addr(maddr_o[0]), .message_size(msize_o[0]),
      .done(done), .hash(hash), .h_valid(hv_o[0]), .h_ready(h_ready), .h_data(hd_o[0]), .h_last(hl_o[0]),
      .busy(busy_o[0]), .overflow(ovf_o[0])
   );

   sha1_msg_loader #(.MAX_BYTES(8), .ADDR_W(16)) dut1 (
      .clk(clk), .reset(reset), .base_addr(base_addr),
      .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_data(s_data), .s_last(s_last),
      .port_B_clk(pclk_o[1]), .port_B_addr(paddr_o[1]), .port_B_data_in(pdata_o[1]), .port_B_we(pwe_o[1]),
      .core_nreset(cnr_o[1]), .start_hash(start_o[1]), .message_addr(maddr_o[1]), .message_size(msize_o[1]),
      .done(done), .hash(hash), .h_valid(hv_o[1]), .h_ready(h_ready), .h_data(hd_o[1]), .h_last(hl_o[1]),
      .busy(busy_o[1]), .overflow(ovf_o[1])
   );

   assign m_s_ready = s_ready_o[sel];
   assign m_we      = pwe_o[sel];
   assign m_cnr     = cnr_o[sel];
   assign m_start   = start_o[sel];
   assign m_hv      = hv_o[sel];
   assign m_hl      = hl_o[sel];
   assign m_busy    = busy_o[sel];
   assign m_ovf     = ovf_o[sel];
   assign m_paddr   = paddr_o[sel];
   assign m_pdata   = pdata_o[sel];
   assign m_maddr   = maddr_o[sel];
   assign m_msize   = msize_o[sel];
   assign m_hd      = hd_o[sel];

   // SRAM write capture plus a hasher that raises a sticky done a few cycles after start
   always @(negedge clk) begin
      if (m_we) wq.push_back({m_paddr, m_pdata});
      if (!reset && !m_cnr) nres_lows++;
      if (m_start) begin
         starts++;
         cap_size = m_msize;
         cap_addr = m_maddr;
      end
      if (reset || !m_cnr) begin
         done = 1'b0;
         hash_cnt = 0;
      end else if (m_start) begin
         hash_cnt = 3 + $urandom_range(0, 5);
         hash = ~cur_digest;
      end else if (hash_cnt > 0) begin
         hash_cnt--;
         if (hash_cnt == 0) begin
            done = 1'b1;
            hash = cur_digest;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      s_valid = 1'b0;
      s_last = 1'b0;
      h_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps, input bit scramble);
      int g;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(negedge clk);
         s_valid = 1'b0;
         s_last = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = b;
      s_last = last;
      if (scramble) base_addr = 16'($urandom);
      g = 0;
      while (!m_s_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!m_s_ready) timeout_fail("s_ready_wait");
      @(posedge clk);
   endtask

   task automatic run_job(input bit s, input logic [15:0] base, input byte_q_t bytes,
                          input logic [159:0] dig, input bit stall, input bit gaps, input string tag,
                          output int nwr, output logic [31:0] size, output logic ovf, output logic [31:0] w0);
      int maxb, kept, nw, wq0, st0, nr0, g, n;
      logic [31:0] ed, hold;
      logic [15:0] ea;
      n = bytes.size();
      maxb = s ? 8 : 64;
      wq0 = wq.size();
      st0 = starts;
      nr0 = nres_lows;
      cur_digest = dig;
      base_addr = base;
      for (int i = 0; i < n; i++) send_byte(bytes[i], i == n - 1, gaps, i > 0);
      @(negedge clk);
      s_valid = 1'b0;
      s_last = 1'b0;
      for (int w = 0; w < DIGEST_WORDS; w++) begin
         @(negedge clk);
         h_ready = 1'b0;
         g = 0;
         while (!m_hv && g < 200) begin
            @(negedge clk);
            g++;
         end
         if (!m_hv) begin
            timeout_fail({tag, "_h_valid"});
            break;
         end
         if (stall) begin
            hold = m_hd;
            repeat (3) @(negedge clk);
            chk($sformatf("%s_stall_data%0d", tag, w), m_hd, hold);
            chk($sformatf("%s_stall_valid%0d", tag, w), m_hv, 1'b1);
         end
         chk($sformatf("%s_hdata%0d", tag, w), m_hd, 32'(dig >> (32 * (4 - w))));
         chk($sformatf("%s_hlast%0d", tag, w), m_hl, (w == 4));
         h_ready = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      h_ready = 1'b0;
      chk({tag, "_busy_after"}, m_busy, 1'b0);
      chk({tag, "_s_ready_after"}, m_s_ready, 1'b1);
      kept = (n < maxb) ? n : maxb;
      nw = (kept + 3) / 4;
      nwr = wq.size() - wq0;
      chk({tag, "_nwrites"}, nwr, nw);
      for (int w = 0; w < nw && wq0 + w < wq.size(); w++) begin
         ed = 32'd0;
         for (int j = 0; j < 4; j++)
            if (4 * w + j < kept) ed = ed | (32'(bytes[4 * w + j]) << (8 * j));
         ea = base + 16'(4 * w);
         chk($sformatf("%s_waddr%0d", tag, w), wq[wq0 + w].a, ea);
         chk($sformatf("%s_wdata%0d", tag, w), wq[wq0 + w].d, ed);
      end
      w0 = (nwr > 0) ? wq[wq0].d : 32'hdeadbeef;
      size = cap_size;
      ovf = m_ovf;
      chk({tag, "_msize"}, cap_size, 32'(kept));
      chk({tag, "_maddr"}, cap_addr, {16'h0000, base});
      chk({tag, "_starts"}, starts - st0, 1);
      chk({tag, "_nreset_lows"}, nres_lows - nr0, 1);
      chk({tag, "_overflow"}, m_ovf, (n > maxb));
   endtask

   vec_t    vecs[5];
   byte_q_t q;
   int      nwr;
   logic [31:0] sz, w0;
   logic    ovf;
   int      n0;
   string   s6;

   initial begin
      vecs[0] = '{1'b0, 16'h0100, "abc", 160'ha9993e364706816aba3e25717850c26c9cd0d89d,
                  1'b0, 1, 32'd3, 1'b0, 32'h00636261};
      vecs[1] = '{1'b0, 16'h2000, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
                  160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 1'b0, 14, 32'd56, 1'b0, 32'h64636261};
      vecs[2] = '{1'b0, 16'h0010, "abcd", 160'h0123456789abcdef0011223344556677deadbeef,
                  1'b0, 1, 32'd4, 1'b0, 32'h64636261};
      vecs[3] = '{1'b1, 16'h0040, "hello world", 160'hfedcba98765432100f1e2d3c4b5a69788badf00d,
                  1'b0, 2, 32'd8, 1'b1, 32'h6c6c6568};
      vecs[4] = '{1'b0, 16'hfffc, "abcdefg", 160'ha9993e364706816aba3e25717850c26c9cd0d89d,
                  1'b1, 2, 32'd7, 1'b0, 32'h64636261};

      repeat (2) @(negedge clk);
      chk("rst_ctrl", {m_s_ready, m_we, m_start, m_hv, m_hl, m_busy, m_ovf, m_cnr}, 8'h00);
      chk("rst_paddr", m_paddr, 16'h0000);
      chk("rst_pdata", m_pdata, 32'h0);
      chk("rst_msg", {m_maddr, m_msize}, 64'h0);
      chk("rst_hdata", m_hd, 32'h0);
      reset = 1'b0;

      for (int k = 0; k < 5; k++) begin
         if (vecs[k].sel != sel) begin
            sel = vecs[k].sel;
            do_reset();
         end
         q.delete();
         for (int i = 0; i < vecs[k].msg.len(); i++) q.push_back(vecs[k].msg[i]);
         run_job(vecs[k].sel, vecs[k].base, q, vecs[k].digest, vecs[k].stall, 1'b0,
                 $sformatf("v%0d", k), nwr, sz, ovf, w0);
         chk($sformatf("v%0d_tab_writes", k), nwr, vecs[k].exp_writes);
         chk($sformatf("v%0d_tab_size", k), sz, vecs[k].exp_size);
         chk($sformatf("v%0d_tab_ovf", k), ovf, vecs[k].exp_ovf);
         chk($sformatf("v%0d_tab_w0", k), w0, vecs[k].exp_w0);
      end

      // reset in the middle of FILL: word 0 already written, lanes 4..5 discarded
      s6 = "abcdef";
      base_addr = 16'h0300;
      n0 = wq.size();
      for (int i = 0; i < 6; i++) send_byte(s6[i], 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", m_busy, 1'b0);
      chk("midrst_s_ready_in_reset", m_s_ready, 1'b0);
      chk("midrst_core_nreset", m_cnr, 1'b0);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_nwrites", wq.size() - n0, 1);
      if (wq.size() > n0) chk("midrst_w0", wq[n0], {16'h0300, 32'h64636261});
      chk("midrst_idle", {m_busy, m_s_ready, m_we}, 3'b010);
      q = '{8'h61, 8'h62, 8'h63};
      run_job(1'b0, 16'h0100, q, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b0, 1'b0,
              "post_rst", nwr, sz, ovf, w0);

      for (int r = 0; r < 10; r++) begin
         int len;
         len = $urandom_range(1, 80);
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
         run_job(1'b0, 16'($urandom), q, {$urandom, $urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", r), nwr, sz, ovf, w0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
